// File: rtl/pio_sched_pkg.sv
// Shared types and default sizing for the PIO round-robin scheduler.
package pio_sched_pkg;

    localparam int N_CH_DEFAULT    = 8;
    localparam int DW_DEFAULT      = 8;
    localparam int CH_W_DEFAULT    = $clog2(N_CH_DEFAULT);
    localparam int TIMEOUT_DEFAULT = 255;

    // Transaction phases of the aux-path owner
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request at or above ptr, wrapping to 0.
module rr_pick
    import pio_sched_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    parameter int CH_W = CH_W_DEFAULT
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            found,
    output logic [CH_W-1:0] index
);

    logic [2*N_CH-1:0] req_dbl;
    logic [N_CH-1:0]   req_rot;
    logic [CH_W-1:0]   offset;

    // Rotating the doubled vector puts channel ptr at bit 0, so the lowest
    // set bit of req_rot is the distance from ptr to the winner.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[N_CH-1:0];

    // Lowest set bit of the rotated request vector
    always_comb begin
        offset = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = CH_W'(i);
            end
        end
    end

    assign found = |req;
    // N_CH is a power of two, so the CH_W-bit add wraps modulo N_CH
    assign index = ptr + offset;

endmodule

// File: rtl/pio_rr_scheduler.sv
// Round-robin owner of the shared aux processing path for the PIO channels.
module pio_rr_scheduler
    import pio_sched_pkg::*;
#(
    parameter int N_CH    = N_CH_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CH_W    = $clog2(N_CH)
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [N_CH-1:0]    req,
    input  logic [N_CH*DW-1:0] in_data,
    output logic [DW-1:0]      aux_out_data,
    output logic               aux_out_valid,
    output logic [CH_W-1:0]    aux_out_ch,
    input  logic [DW-1:0]      aux_in_data,
    input  logic               aux_in_valid,
    output logic [N_CH*DW-1:0] out_data,
    output logic [N_CH-1:0]    out_valid,
    output logic [N_CH-1:0]    grant,
    output logic [N_CH-1:0]    err,
    input  logic               err_clr,
    output logic               busy
);

    localparam int              TW       = $clog2(TIMEOUT + 1);
    // Counter value on the edge where the TIMEOUT-th WAIT cycle ends
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    sched_state_t    state_reg, state_next;
    logic [CH_W-1:0] ptr_reg;
    logic [CH_W-1:0] ch_reg;
    logic [DW-1:0]   aux_data_reg;
    logic            aux_valid_reg;
    logic [N_CH-1:0] grant_reg;
    logic [TW-1:0]   cnt_reg;
    logic [DW-1:0]   resp_reg;

    logic            pick_found;
    logic [CH_W-1:0] pick_index;

    logic            load_next;
    logic            issue_next;
    logic            resp_next;
    logic            tmo_next;
    logic            done_next;

    rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .found (pick_found),
        .index (pick_index)
    );

    // State register
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus the one-cycle action strobes that steer the datapath
    always_comb begin
        state_next = state_reg;
        load_next  = 1'b0;
        issue_next = 1'b0;
        resp_next  = 1'b0;
        tmo_next   = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    load_next  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue_next = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A response on the last allowed cycle still counts
                if (aux_in_valid) begin
                    resp_next  = 1'b1;
                    state_next = DONE;
                end else if (cnt_reg == TMO_LAST) begin
                    tmo_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shared datapath: channel capture, aux handshake, timeout counter, pointer
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            ptr_reg       <= '0;
            ch_reg        <= '0;
            aux_data_reg  <= '0;
            aux_valid_reg <= 1'b0;
            grant_reg     <= '0;
            cnt_reg       <= '0;
            resp_reg      <= '0;
        end else begin
            if (load_next) begin
                // Byte is frozen here so later in_data changes do not leak through
                ch_reg       <= pick_index;
                aux_data_reg <= in_data[pick_index*DW +: DW];
            end
            if (issue_next) begin
                grant_reg     <= N_CH'(1) << ch_reg;
                aux_valid_reg <= 1'b1;
                cnt_reg       <= '0;
            end
            if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg + TW'(1);
            end
            if (resp_next) begin
                resp_reg <= aux_in_data;
            end
            if (tmo_next || done_next) begin
                grant_reg     <= '0;
                aux_valid_reg <= 1'b0;
                ptr_reg       <= ch_reg + CH_W'(1);
            end
        end
    end

    // Per-channel result register, update pulse and sticky timeout flag
    for (genvar gi = 0; gi < N_CH; gi++) begin : gen_ch
        logic          sel;
        logic [DW-1:0] data_reg;
        logic          valid_reg;
        logic          err_reg;

        assign sel = (ch_reg == CH_W'(gi));

        // A timeout set in the same cycle as err_clr takes priority
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
                err_reg   <= 1'b0;
            end else begin
                valid_reg <= done_next && sel;
                if (done_next && sel) begin
                    data_reg <= resp_reg;
                end
                err_reg <= (tmo_next && sel) || (err_reg && !err_clr);
            end
        end

        assign out_data[gi*DW +: DW] = data_reg;
        assign out_valid[gi]         = valid_reg;
        assign err[gi]               = err_reg;
    end

    assign aux_out_data  = aux_data_reg;
    assign aux_out_valid = aux_valid_reg;
    assign aux_out_ch    = ch_reg;
    assign grant         = grant_reg;
    assign busy          = (state_reg != IDLE);

endmodule
